fsm_bspg: RTL and testbench
===========================

// Module: fsm_bspg
// PURPOSE
//   Serial bitstream pattern generator: the transmit end of the serial
//   bit_in stream consumed by the bitstream pattern detector.
//   Accepts a parallel word over a valid/ready handshake and shifts it
//   out one bit per clock, MSB first, with a programmable idle gap between words.
//   Drives the detector's bit_in in the Lab4a test harness.
// PARAMETERS
//   WIDTH   8   bits per word, >= 2
//   GAP     0   idle cycles inserted after each word, 0..255
//   IDLE_LV 0   value driven on bit_out while not shifting
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   in_valid   in   1      in_data is valid this cycle
//   in_data    in   WIDTH  word to serialise
//   in_ready   out  1      block accepts a word this cycle
//   bit_out    out  1      serial data, MSB first
//   bit_valid  out  1      bit_out carries a data bit this cycle
//   word_done  out  1      one-cycle pulse with the LSB of each word
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, shift reg=0, counters=0,
//   in_ready=0, bit_out=IDLE_LV, bit_valid=0, word_done=0.
//   in_ready rises on the first clk edge after reset deasserts.
// - Handshake: a word transfers on a clk edge where in_valid && in_ready.
//   in_data is sampled only on that edge. in_valid without in_ready has no effect.
// - in_ready=1 in these cases:
//   - in IDLE
//   - in SHIFT on the last bit when GAP==0
//   - in GAP on the last gap cycle
// - All outputs are registered.
//   - The MSB appears on bit_out with bit_valid=1 in the cycle after the accepting edge.
//   - Each following bit holds for exactly one cycle.
// - FSM states and transitions:
//   - IDLE -> SHIFT on accept. Load the shift register and set bit_cnt=WIDTH-1.
//   - SHIFT: drive MSB, shift left, decrement bit_cnt.
//     - On bit_cnt==0 assert word_done.
//     - Next state on that cycle:
//       - GAP when GAP>0.
//       - SHIFT with the new word when GAP==0 and a word was accepted.
//       - IDLE otherwise.
//   - GAP: bit_out=IDLE_LV, bit_valid=0 for exactly GAP cycles.
//     - Then SHIFT if a word was accepted on the last gap cycle, else IDLE.
// - Back-to-back: with GAP==0 and in_valid held high, bit_valid stays 1
//   continuously with no idle cycle between words.
// - Counters: bit_cnt is $clog2(WIDTH) bits and gap_cnt is 8 bits.
//   Neither counter wraps; each is reloaded on every use.
// - in_valid dropping mid-word does not disturb the word in flight.
// - Reset mid-word aborts the word immediately.
//   - No word_done for the aborted word.
//   - bit_valid=0 in the same cycle reset asserts.
// - Unused/default FSM encodings recover to IDLE with outputs at reset values.
// TESTING
// 1. Reset: hold reset=0 for 3 clk, with in_valid=1 -> in_ready=0,
//    bit_valid=0, bit_out=IDLE_LV throughout, no word accepted.
// 2. Single word, WIDTH=8, GAP=0, in_data=8'hA6 ->
//    bit_out=1,0,1,0,0,1,1,0 on 8 consecutive cycles, starting 1 cycle
//    after accept; word_done high only with the final 0; then IDLE.
// 3. Back-to-back: 8'hF0 then 8'h0F with in_valid held, GAP=0 ->
//    16 contiguous valid bits 1111000000001111; word_done at bits 8 and 16;
//    second accept coincides with bit 8.
// 4. Gap: GAP=3, two words 8'h81, 8'h7E -> exactly 3 cycles with bit_valid=0
//    between them; in_ready high only on the 3rd gap cycle.
// 5. Abort: assert reset after 4 bits of 8'hFF -> bit_valid falls in the same
//    cycle, no word_done; the next word 8'h01 then shifts out cleanly.
// 6. Detector loopback: drive the detector with a stream containing 1110 ->
//    det_out asserts exactly once, on the cycle the final 0 is on bit_out.

Source files
------------

// File: rtl/fsm_bspg_if.sv
// fsm_bspg_if: parallel word handshake into the generator and serial bit stream out of it.
interface fsm_bspg_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             word_done;
    modport master (output in_valid, in_data, input in_ready, bit_out, bit_valid, word_done);
    modport slave  (input in_valid, in_data, output in_ready, bit_out, bit_valid, word_done);
endinterface

// File: rtl/fsm_bspg.sv
// fsm_bspg: serialises handshaked words MSB first with a programmable idle gap between words.
module fsm_bspg #(
    parameter int   WIDTH   = 8,
    parameter int   GAP     = 0,
    parameter logic IDLE_LV = 1'b0
) (
    input logic       clk,
    input logic       reset,
    fsm_bspg_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             rdy_q, rdy_d, bit_q, bit_d, vld_q, vld_d, done_q, done_d;
    logic             acc;
    assign acc = bus.in_valid && rdy_q && (state_q inside {S_IDLE, S_SHIFT, S_GAP});
    // in_ready is registered, so it is raised one cycle ahead of the cycle that may accept
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rdy_d     = 1'b0;
        bit_d     = IDLE_LV;
        vld_d     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: rdy_d = 1'b1;
            S_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    bit_d     = sh_q[WIDTH-1];
                    sh_d      = sh_q << 1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    vld_d     = 1'b1;
                    done_d    = bit_cnt_q == CW'(1);
                    rdy_d     = done_d && (GAP == 0);
                end else if (GAP > 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 8'(GAP - 1);
                    rdy_d     = GAP == 1;
                end else begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                end
            end
            S_GAP: begin
                state_d   = gap_cnt_q == '0 ? S_IDLE : S_GAP;
                gap_cnt_d = gap_cnt_q == '0 ? gap_cnt_q : gap_cnt_q - 8'd1;
                rdy_d     = gap_cnt_q <= 8'd1;
            end
            default: begin
                state_d   = S_IDLE;
                sh_d      = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
        if (acc) begin
            state_d   = S_SHIFT;
            bit_d     = bus.in_data[WIDTH-1];
            sh_d      = bus.in_data << 1;
            bit_cnt_d = CW'(WIDTH - 1);
            vld_d     = 1'b1;
            done_d    = 1'b0;
            rdy_d     = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rdy_q     <= 1'b0;
            bit_q     <= IDLE_LV;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rdy_q     <= rdy_d;
            bit_q     <= bit_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
        end
    end
    assign bus.in_ready  = rdy_q;
    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = vld_q;
    assign bus.word_done = done_q;
endmodule

// File: tb/tb_fsm_bspg.sv
// tb_fsm_bspg: two generators (GAP=0 and GAP=3) checked every cycle against a cycle-scheduled reference.
module tb_fsm_bspg;
    localparam int W   = 8;
    localparam int BIG = 32'h7fff_ffff;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;
    fsm_bspg_if #(.WIDTH(W)) b0 ();
    fsm_bspg_if #(.WIDTH(W)) b3 ();
    fsm_bspg #(.WIDTH(W), .GAP(0), .IDLE_LV(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    fsm_bspg #(.WIDTH(W), .GAP(3), .IDLE_LV(1'b0)) u3 (.clk(clk), .reset(reset), .bus(b3));
    logic         vld [2];
    logic [W-1:0] dat [2];
    assign b0.in_valid = vld[0];
    assign b0.in_data  = dat[0];
    assign b3.in_valid = vld[1];
    assign b3.in_data  = dat[1];
    int           cyc = 0, n_chk = 0, n_fail = 0;
    bit           dense = 1'b1;
    int           ready_at [2] = '{BIG, BIG};
    bit [2:0]     sch [2][64];
    logic [W-1:0] q0 [$], q1 [$];
    // reference: an accepted word occupies the next W cycles; ready returns W+GAP cycles after accept
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                for (int i = 0; i < 64; i++) sch[k][i] = 3'b0;
                ready_at[k] = BIG;
            end else begin
                sch[k][cyc % 64] = 3'b0;
                if (vld[k] && cyc >= ready_at[k]) begin
                    logic [W-1:0] w;
                    if (k == 0) w = q0.pop_front();
                    else w = q1.pop_front();
                    for (int i = 0; i < W; i++) sch[k][(cyc + 1 + i) % 64] = {1'b1, w[W-1-i], i == W - 1};
                    ready_at[k] = cyc + W + (k == 0 ? 0 : 3);
                end else if (ready_at[k] == BIG) ready_at[k] = cyc + 1;
            end
        end
        cyc++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] got;
            logic [2:0] e;
            logic       rdy;
            got = k == 0 ? {b0.in_ready, b0.bit_valid, b0.bit_out, b0.word_done}
                         : {b3.in_ready, b3.bit_valid, b3.bit_out, b3.word_done};
            e   = reset ? sch[k][cyc % 64] : 3'b0;
            rdy = reset && cyc >= ready_at[k];
            check($sformatf("gap%0d_in_ready", k * 3), 32'(got[3]), 32'(rdy));
            check($sformatf("gap%0d_bit_valid", k * 3), 32'(got[2]), 32'(e[2]));
            check($sformatf("gap%0d_bit_out", k * 3), 32'(got[1]), 32'(e[2] ? e[1] : 1'b0));
            check($sformatf("gap%0d_word_done", k * 3), 32'(got[0]), 32'(e[0]));
        end
    endtask
    task automatic step();
        @(negedge clk);
        check_all();
        for (int k = 0; k < 2; k++) begin
            int sz;
            sz     = k == 0 ? q0.size() : q1.size();
            vld[k] = sz > 0 && (dense || $urandom_range(0, 3) != 0);
            dat[k] = sz == 0 ? W'($urandom) : (k == 0 ? q0[0] : q1[0]);
        end
    endtask
    task automatic push2(input logic [W-1:0] w);
        q0.push_back(w);
        q1.push_back(w);
    endtask
    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_in_time", 32'(n < 300), 32'd1);
        repeat (W + 6) step();
    endtask
    task automatic pulse_reset();
        reset = 1'b0;
        #1 check_all();
        repeat (2) step();
        reset = 1'b1;
    endtask
    initial begin
        int n;
        vld = '{1'b0, 1'b0};
        dat = '{'0, '0};
        push2(8'h3C);
        repeat (3) step();
        reset = 1'b1;
        drain();
        push2(8'hA6);
        drain();
        push2(8'hF0);
        push2(8'h0F);
        drain();
        push2(8'h81);
        push2(8'h7E);
        drain();
        push2(8'hFF);
        n = 0;
        while (q0.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("abort_accept", 32'(n < 50), 32'd1);
        repeat (3) step();
        pulse_reset();
        push2(8'h01);
        drain();
        push2(8'hEE);
        push2(8'h0E);
        drain();
        dense = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(W'($urandom));
            if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(W'($urandom));
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else step();
        end
        dense = 1'b1;
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
